// File: rtl/booth_mul_pipe.sv
// booth_mul_pipe: three-stage pipelined radix-4 Booth multiplier for the
// RV32M multiply ops (mul, mulh, mulhsu, mulhu) at any even XLEN >= 8.
//   P stage : operand extension + Booth partial products
//   C stage : 4:2 / 3:2 carry-save reduction to a sum/carry pair
//   R stage : carry-lookahead final add, result slice selected by op
// Ports:
//   clk, rst (sync, active low)
//   in_valid/in_ready, op, a, b, tag : operation input handshake
//   flush                            : drops every in-flight operation
//   out_valid/out_ready, result, out_tag : result output handshake
// A single global advance signal stalls every stage while the output
// holds an unaccepted result.
module booth_mul_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned W2  = 2 * XLEN;
  localparam int unsigned NPP = XLEN / 2 + 1;
  localparam int unsigned MW  = XLEN + 3;
  localparam int unsigned IW  = $clog2(NPP);

  logic advance;
  logic accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = rst && advance;
  assign accept   = in_valid && in_ready && !flush;

  // 3:2 carry-save adder, returns {sum, carry<<1}
  function automatic logic [2*W2-1:0] csa32(input logic [W2-1:0] x0, x1, x2);
    logic [W2-1:0] s;
    logic [W2-1:0] c;
    s = x0 ^ x1 ^ x2;
    c = ((x0 & x1) | (x0 & x2) | (x1 & x2)) << 1;
    return {s, c};
  endfunction

  // 4:2 compressor built from two chained 3:2 cells, returns {sum, carry<<1}
  function automatic logic [2*W2-1:0] comp42(input logic [W2-1:0] x0, x1, x2, x3);
    logic [2*W2-1:0] r1;
    r1 = csa32(x0, x1, x2);
    return csa32(r1[2*W2-1:W2], r1[W2-1:0], x3);
  endfunction

  // ---------------- P stage ----------------
  logic [W2-1:0]    pp_d [NPP];
  logic [W2-1:0]    pp_q [NPP];
  logic [1:0]       op1;
  logic [TAG_W-1:0] tag1;
  logic             v1;

  always_comb begin
    logic [W2-1:0] mcand;
    logic [MW-1:0] mlier;
    logic [2:0]    dig;
    logic [W2-1:0] sel;
    // a is signed except for mulhu; b is signed only for mul/mulh
    mcand = {{XLEN{(op != 2'b11) & a[XLEN-1]}}, a};
    mlier = {{2{!op[1] & b[XLEN-1]}}, b, 1'b0};
    dig   = '0;
    sel   = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      dig = 3'(mlier >> (2 * i));
      unique case (dig)
        3'b001, 3'b010: sel = mcand;
        3'b011:         sel = mcand << 1;
        3'b100:         sel = -(mcand << 1);
        3'b101, 3'b110: sel = -mcand;
        default:        sel = '0;
      endcase
      pp_d[IW'(i)] = sel << (2 * i);
    end
  end

  // ---------------- C stage ----------------
  logic [W2-1:0]    sum_d, carry_d;
  logic [W2-1:0]    sum_q, carry_q;
  logic [1:0]       op2;
  logic [TAG_W-1:0] tag2;
  logic             v2;

  // Each level consumes rows four at a time through 4:2 compressors, a
  // leftover group of three through a 3:2 cell, and passes up to two rows
  // straight through; levels repeat until only sum and carry remain.
  always_comb begin
    logic [W2-1:0]   cur [NPP];
    logic [W2-1:0]   nxt [NPP];
    logic [2*W2-1:0] r;
    int unsigned     n, m, j;
    r = '0;
    n = NPP;
    m = 0;
    j = 0;
    for (int unsigned i = 0; i < NPP; i++) begin
      cur[IW'(i)] = pp_q[IW'(i)];
      nxt[IW'(i)] = '0;
    end
    for (int unsigned lvl = 0; lvl < NPP; lvl++) begin
      if (n > 2) begin
        m = 0;
        j = 0;
        for (int unsigned g = 0; g < NPP / 4; g++) begin
          if (j + 4 <= n) begin
            r = comp42(cur[IW'(j)], cur[IW'(j+1)], cur[IW'(j+2)], cur[IW'(j+3)]);
            nxt[IW'(m)]   = r[2*W2-1:W2];
            nxt[IW'(m+1)] = r[W2-1:0];
            m += 2;
            j += 4;
          end
        end
        if (n - j == 3) begin
          r = csa32(cur[IW'(j)], cur[IW'(j+1)], cur[IW'(j+2)]);
          nxt[IW'(m)]   = r[2*W2-1:W2];
          nxt[IW'(m+1)] = r[W2-1:0];
          m += 2;
          j += 3;
        end
        for (int unsigned k = 0; k < 2; k++) begin
          if (j < n) begin
            nxt[IW'(m)] = cur[IW'(j)];
            m++;
            j++;
          end
        end
        for (int unsigned i = 0; i < NPP; i++) cur[IW'(i)] = nxt[IW'(i)];
        n = m;
      end
    end
    sum_d   = cur[0];
    carry_d = cur[1];
  end

  // ---------------- R stage ----------------
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] res_d;

  // Kogge-Stone prefix carry-lookahead adder
  always_comb begin
    logic [W2-1:0] p, gg, pg;
    p  = sum_q ^ carry_q;
    gg = sum_q & carry_q;
    pg = p;
    for (int unsigned d = 1; d < W2; d = d * 2) begin
      gg = gg | (pg & (gg << d));
      pg = pg & (pg << d);
    end
    prod  = p ^ (gg << 1);
    res_d = (op2 == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      v1        <= accept;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      result  <= '0;
      out_tag <= '0;
    end else if (advance) begin
      result  <= res_d;
      out_tag <= tag2;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      pp_q    <= pp_d;
      op1     <= op;
      tag1    <= tag;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      op2     <= op1;
      tag2    <= tag1;
    end
  end

endmodule

// File: tb/tb_booth_mul_pipe.sv
// Scoreboard bench for booth_mul_pipe at XLEN=32 and XLEN=16.
module tb_booth_mul_pipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int unsigned acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  tag, out_tag;

  logic        in_valid_h, in_ready_h, flush_h, out_valid_h, out_ready_h;
  logic [1:0]  op_h;
  logic [15:0] a_h, b_h, result_h;
  logic [4:0]  tag_h, out_tag_h;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          rmode = 0;
  bit          lat_on = 1'b1;
  exp_t        q[$];
  exp_t        q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mul_pipe #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .tag(tag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .out_tag(out_tag));

  booth_mul_pipe #(.XLEN(16), .TAG_W(5)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_h), .in_ready(in_ready_h), .op(op_h),
    .a(a_h), .b(b_h), .tag(tag_h), .flush(flush_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .result(result_h), .out_tag(out_tag_h));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    ex = {{32{(o != 2'b11) & x[31]}}, x};
    ey = {{32{!o[1] & y[31]}}, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input logic [31:0] e, input bit push);
    int unsigned w;
    op = o; a = x; b = y; tag = t; in_valid = 1'b1; w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout tag=%0d in_ready=%b required=1", t, in_ready);
    end else if (push) begin
      q.push_back('{res: e, tag: t, acc: cyc, lat: lat_on});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [4:0] t, input logic [15:0] e);
    op_h = o; a_h = x; b_h = y; tag_h = t; in_valid_h = 1'b1;
    @(negedge clk);
    chk("in_ready16", 32'(in_ready_h), 32'd1);
    if (in_ready_h) q16.push_back('{res: 32'(e), tag: t, acc: cyc, lat: 1'b1});
    @(posedge clk); #1;
    in_valid_h = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && q16.size() == 0) break;
    end
    @(posedge clk); #1;
  endtask

  // out_ready generator: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = held low
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor for the 32-bit instance
  initial begin
    logic        pv_stall;
    logic [31:0] pres;
    logic [4:0]  ptag;
    exp_t        e;
    pv_stall = 1'b0;
    pres = '0;
    ptag = '0;
    forever begin
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(rst && (!out_valid || out_ready)));
      if (pv_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_result", result, pres);
        chk("stall_tag", 32'(out_tag), 32'(ptag));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output tag=%0d result=%h required=none", out_tag, result);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("out_tag", 32'(out_tag), 32'(e.tag));
          if (e.lat) chk("latency", cyc - e.acc, 32'd3);
        end
      end
      pv_stall = out_valid && !out_ready && rst && !flush;
      pres = result;
      ptag = out_tag;
    end
  end

  // Monitor for the 16-bit instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid_h && out_ready_h) begin
        if (q16.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output16 tag=%0d result=%h required=none", out_tag_h, result_h);
        end else begin
          e = q16.pop_front();
          chk("result16", 32'(result_h), e.res);
          chk("out_tag16", 32'(out_tag_h), 32'(e.tag));
          chk("latency16", cyc - e.acc, 32'd3);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; tag = '0;
    in_valid_h = 1'b0; flush_h = 1'b0; out_ready_h = 1'b1; op_h = '0; a_h = '0; b_h = '0; tag_h = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // signed corner cases
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, 1'b1);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000000, 1'b1);
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'hFFFFFFFE, 1'b1);
    issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 1'b1);
    // overflow extremes
    issue(2'b01, 32'h80000000, 32'h80000000, 5'd5, 32'h40000000, 1'b1);
    issue(2'b11, 32'h80000000, 32'h00000002, 5'd6, 32'h00000001, 1'b1);
    issue(2'b00, 32'h00010000, 32'h00010000, 5'd7, 32'h00000000, 1'b1);
    wait_drain();

    // streaming, tags 0..9
    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = $urandom;
      issue(ro, ra, rb, 5'(i), ref32(ro, ra, rb), 1'b1);
    end
    wait_drain();

    // backpressure with out_ready 1-0-0-1
    lat_on = 1'b0;
    rmode = 1;
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      rb = $urandom;
      issue(ro, ra, rb, 5'(10 + i), ref32(ro, ra, rb), 1'b1);
    end
    wait_drain();
    rmode = 0;
    out_ready = 1'b1;
    lat_on = 1'b1;
    @(posedge clk); #1;

    // flush: the oldest op reaches the output in the flush cycle and is taken
    // by the consumer there; the two younger ops and the flush-cycle op vanish
    issue(2'b00, 32'h00001234, 32'h00000010, 5'd20, 32'h00012340, 1'b1);
    issue(2'b00, 32'h00000005, 32'h00000006, 5'd21, 32'h0, 1'b0);
    issue(2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd22, 32'h0, 1'b0);
    flush = 1'b1;
    issue(2'b00, 32'h00000009, 32'h00000009, 5'd23, 32'h0, 1'b0);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      if (i == 0) chk("flush_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end

    // reset mid-stream
    issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd25, 32'h0, 1'b0);
    issue(2'b00, 32'h0000000B, 32'h0000000D, 5'd26, 32'h0, 1'b0);
    rmode = 2;
    out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_out_tag", 32'(out_tag), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    rmode = 0;
    out_ready = 1'b1;
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 5'd9, 32'hFFFFFFEB, 1'b1);
    wait_drain();

    // XLEN=16 instance
    issue16(2'b11, 16'hFFFF, 16'hFFFF, 5'd1, 16'hFFFE);
    issue16(2'b00, 16'hFFFF, 16'hFFFF, 5'd2, 16'h0001);
    issue16(2'b01, 16'hFFFF, 16'hFFFF, 5'd3, 16'h0000);
    issue16(2'b10, 16'hFFFF, 16'hFFFF, 5'd4, 16'hFFFF);
    issue16(2'b00, 16'h0007, 16'hFFFD, 5'd5, 16'hFFEB);
    issue16(2'b01, 16'h8000, 16'h8000, 5'd6, 16'h4000);
    wait_drain();

    chk("scoreboard_empty", 32'(q.size() + q16.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
